// File: rtl/frame_serializer_if.sv
// Message-source / serializer handshake for frame_serializer.
// master = message source side, slave = serializer side.
interface frame_serializer_if #(
    parameter int unsigned MSG_W = 5
);
    logic             send;
    logic [MSG_W-1:0] msg;
    logic             ser_out;
    logic             bit_start;
    logic             busy;
    logic             done;

    modport master (
        output send,
        output msg,
        input  ser_out,
        input  bit_start,
        input  busy,
        input  done
    );

    modport slave (
        input  send,
        input  msg,
        output ser_out,
        output bit_start,
        output busy,
        output done
    );
endinterface

// File: rtl/frame_serializer.sv
// Framed MSB-first serial transmitter: {PREAMBLE, msg[, parity]}, BIT_CYC clocks per bit.
// Optional even-parity bit after the message LSB when FRAME_PARITY_EN is defined.
module frame_serializer #(
    parameter int unsigned          MSG_W    = 5,
    parameter int unsigned          PRE_W    = 4,
    parameter logic [PRE_W-1:0]     PREAMBLE = PRE_W'(4'b0101),
    parameter int unsigned          BIT_CYC  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    frame_serializer_if.slave   bus
);

`ifdef FRAME_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    localparam int unsigned FRAME_W = PRE_W + MSG_W + PAR_W;
    localparam int unsigned DIV_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int unsigned CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int unsigned SHR_W   = FRAME_W - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   cnt;
    // Holds the bits still to go; the bit on the line lives in ser_out.
    logic [SHR_W-1:0]   shreg;
    logic               ser_out;
    logic               bit_start;
    logic               busy;
    logic               done;
    logic [FRAME_W-1:0] frame_c;

    // Frame image assembled from the live message; only captured on accept.
    always_comb begin
`ifdef FRAME_PARITY_EN
        frame_c = {PREAMBLE, bus.msg, ^bus.msg};
`else
        frame_c = {PREAMBLE, bus.msg};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            cnt       <= '0;
            shreg     <= '0;
            ser_out   <= 1'b0;
            bit_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bit_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    ser_out <= 1'b0;
                    busy    <= 1'b0;
                    if (bus.send) begin
                        shreg     <= frame_c[SHR_W-1:0];
                        ser_out   <= frame_c[FRAME_W-1];
                        busy      <= 1'b1;
                        bit_start <= 1'b1;
                        div       <= '0;
                        cnt       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (cnt == CNT_LAST) begin
                            // Last bit period over: release the line and flag completion.
                            cnt     <= '0;
                            ser_out <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            ser_out   <= shreg[SHR_W-1];
                            shreg     <= shreg << 1;
                            cnt       <= cnt + CNT_W'(1);
                            bit_start <= 1'b1;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ser_out   = ser_out;
    assign bus.bit_start = bit_start;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_frame_serializer.sv
// Randomized bench for frame_serializer: two configurations checked every cycle
// against a timeline model (bit index = elapsed / BIT_CYC).
module tb_frame_serializer;

    localparam int unsigned PRE_W     = 4;
    localparam int unsigned A_MSG_W   = 5;
    localparam int unsigned A_BIT_CYC = 4;
    localparam int unsigned B_MSG_W   = 8;
    localparam int unsigned B_BIT_CYC = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frame_serializer_if #(.MSG_W(A_MSG_W)) bus_a ();
    frame_serializer_if #(.MSG_W(B_MSG_W)) bus_b ();

    frame_serializer #(
        .MSG_W    (A_MSG_W),
        .PRE_W    (PRE_W),
        .PREAMBLE (4'b0101),
        .BIT_CYC  (A_BIT_CYC)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    frame_serializer #(
        .MSG_W    (B_MSG_W),
        .PRE_W    (PRE_W),
        .PREAMBLE (4'b0101),
        .BIT_CYC  (B_BIT_CYC)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;
    int now    = 0;

    // Model state per instance (0 = A, 1 = B)
    int start  [2];
    bit active [2];
    bit frm    [2][0:15];
    int fw     [2];
    int bc     [2];
    bit e_ser  [2];
    bit e_bs   [2];
    bit e_busy [2];
    bit e_done [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, now, got, exp);
        end
    endtask

    // Frame as a bit list, first transmitted bit at index 0.
    function automatic void load_frame(input int i, input logic [7:0] m, input int mw);
        logic [3:0] pre;
        int n;
        int ones;
        pre  = 4'b0101;
        n    = 0;
        ones = 0;
        for (int b = PRE_W - 1; b >= 0; b--) begin
            frm[i][n] = pre[b];
            n++;
        end
        for (int b = mw - 1; b >= 0; b--) begin
            frm[i][n] = m[b];
            ones += int'(m[b]);
            n++;
        end
`ifdef FRAME_PARITY_EN
        frm[i][n] = bit'(ones % 2);
        n++;
`endif
        fw[i] = n;
    endfunction

    function automatic void predict(input int i);
        int e;
        e = now - start[i];
        e_ser[i]  = 1'b0;
        e_bs[i]   = 1'b0;
        e_busy[i] = 1'b0;
        e_done[i] = 1'b0;
        if (active[i] && e < fw[i] * bc[i]) begin
            e_busy[i] = 1'b1;
            e_ser[i]  = frm[i][e / bc[i]];
            e_bs[i]   = (e % bc[i]) == 0;
        end else if (active[i] && e == fw[i] * bc[i]) begin
            e_done[i] = 1'b1;
        end
    endfunction

    function automatic void model_edge(input int i, input logic s, input logic [7:0] m, input int mw);
        if (rst) begin
            active[i] = 1'b0;
        end else if (s && !e_busy[i]) begin
            load_frame(i, m, mw);
            start[i]  = now;
            active[i] = 1'b1;
        end
        predict(i);
    endfunction

    task automatic check_outputs();
        check_eq("a.ser_out",   32'(bus_a.ser_out),   32'(e_ser[0]));
        check_eq("a.bit_start", 32'(bus_a.bit_start), 32'(e_bs[0]));
        check_eq("a.busy",      32'(bus_a.busy),      32'(e_busy[0]));
        check_eq("a.done",      32'(bus_a.done),      32'(e_done[0]));
        check_eq("b.ser_out",   32'(bus_b.ser_out),   32'(e_ser[1]));
        check_eq("b.bit_start", 32'(bus_b.bit_start), 32'(e_bs[1]));
        check_eq("b.busy",      32'(bus_b.busy),      32'(e_busy[1]));
        check_eq("b.done",      32'(bus_b.done),      32'(e_done[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        now++;
        model_edge(0, bus_a.send, 8'(bus_a.msg), int'(A_MSG_W));
        model_edge(1, bus_b.send, bus_b.msg, int'(B_MSG_W));
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous abort: outputs must clear without waiting for an edge.
    task automatic reset_now();
        rst = 1'b1;
        #1;
        active[0] = 1'b0;
        active[1] = 1'b0;
        predict(0);
        predict(1);
        check_outputs();
    endtask

    task automatic pulse_send(input logic [4:0] ma, input logic [7:0] mb);
        bus_a.msg  = ma;
        bus_b.msg  = mb;
        bus_a.send = 1'b1;
        bus_b.send = 1'b1;
        tick();
        bus_a.send = 1'b0;
        bus_b.send = 1'b0;
    endtask

    initial begin
        int fwbc;
        rst        = 1'b1;
        bus_a.send = 1'b0;
        bus_b.send = 1'b0;
        bus_a.msg  = '0;
        bus_b.msg  = '0;
        bc[0] = int'(A_BIT_CYC);
        bc[1] = int'(B_BIT_CYC);
        for (int i = 0; i < 2; i++) begin
            start[i]  = 0;
            active[i] = 1'b0;
            fw[i]     = 1;
            predict(i);
        end

        // Reset values, then idle hold
        @(negedge clk);
        check_outputs();
        repeat (3) tick();
        rst = 1'b0;
        repeat (100) tick();

        // Basic frames (parity bit follows the build configuration)
        pulse_send(5'b10110, 8'hA5);
        repeat (45) tick();
        pulse_send(5'b10100, 8'h3C);
        repeat (45) tick();

        // Sends while busy ignored, msg churn mid-frame, send in the done cycle
        pulse_send(5'b10110, 8'h81);
        fwbc = fw[0] * bc[0];
        for (int c = 1; c <= fwbc + 50; c++) begin
            bus_a.send = ((c - 1) == 10) || ((c - 1) == 20) || ((c - 1) == fwbc);
            bus_b.send = ((c - 1) % 5) == 3;
            bus_a.msg  = 5'($urandom);
            bus_b.msg  = 8'($urandom);
            tick();
        end
        bus_a.send = 1'b0;
        bus_b.send = 1'b0;

        // send held high: every frame restarts in the done cycle
        bus_a.send = 1'b1;
        bus_b.send = 1'b1;
        repeat (120) begin
            bus_a.msg = 5'($urandom);
            bus_b.msg = 8'($urandom);
            tick();
        end
        bus_a.send = 1'b0;
        bus_b.send = 1'b0;
        repeat (45) tick();

        // Reset mid-frame, then a clean frame
        pulse_send(5'($urandom), 8'($urandom));
        repeat (13) tick();
        reset_now();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        pulse_send(5'b10110, 8'hF0);
        repeat (45) tick();

        // Random traffic
        repeat (1500) begin
            bus_a.send = ($urandom_range(0, 5) == 0);
            bus_b.send = ($urandom_range(0, 3) == 0);
            bus_a.msg  = 5'($urandom);
            bus_b.msg  = 8'($urandom);
            tick();
        end
        bus_a.send = 1'b0;
        bus_b.send = 1'b0;
        repeat (45) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Parametrised framed serial transmitter for the ASK/FSK modulation front-end. It accepts a parallel message on a one-cycle `send` request and prepends a configurable preamble. The frame goes out MSB first on `ser_out`, each bit held for a programmable number of clock cycles. It sits between the message source and the ASK/FSK modulator, reports `busy`/`done`, and marks every bit boundary for the modulator.

## Interface
- `MSG_W`, 5: message width in bits, ≥1.
- `PRE_W`, 4: preamble width in bits, ≥1.
- `PREAMBLE`, 4'b0101 (`PRE_W` bits): preamble pattern, sent MSB first.
- `BIT_CYC`, 1024: clock cycles per transmitted bit, ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `send`  in  1  frame request, sampled on the rising edge of `clk`.
- `msg`  in  `MSG_W`  message; captured only on an accepted `send`.
- `ser_out`  out  1  serial data, registered.
- `bit_start`  out  1  one-cycle pulse in the first cycle of every frame bit.
- `busy`  out  1  high while a frame is on the line.
- `done`  out  1  one-cycle pulse after the last bit period.

## Operation
- `FRAME_W` = `PRE_W` + `MSG_W` (+1 when parity is enabled). Frame = {`PREAMBLE`, `msg`[, parity]}, transmitted MSB first.
- States:
  - **IDLE**
    - `ser_out`=0, `busy`=0.
    - `send`=1 loads the frame into the shift register, clears the divider and bit counters, and moves to **SHIFT**.
  - **SHIFT**
    - `ser_out` = shift register MSB.
    - The divider counts 0..`BIT_CYC`-1.
    - When the divider reaches `BIT_CYC`-1 with bit count < `FRAME_W`-1: shift left by 1, increment the bit count, reset the divider.
    - When the divider reaches `BIT_CYC`-1 with bit count = `FRAME_W`-1: go to **IDLE** and pulse `done`.
- `send` while `busy`=1: ignored; no re-capture and no queuing.
- `send` in the same cycle as `done`: accepted; that cycle is IDLE.
- `msg` changes after capture have no effect on the frame in flight.
- Counter widths: divider `$clog2(BIT_CYC)` with a minimum of 1 bit; bit counter `$clog2(FRAME_W)` with a minimum of 1 bit. Neither counter wraps past its terminal value.
- `BIT_CYC`=1: one bit per cycle, and `bit_start` is high on every busy cycle.

## Timing
- Reset values: `ser_out`=0, `bit_start`=0, `busy`=0, `done`=0. State is IDLE and all counters and the shift register are 0.
- `rst` asserted mid-frame: immediate abort to the reset values, with no `done` pulse. After release, the block waits for a new `send`.
- Accept latency:
  - `send` is sampled at edge k.
  - From cycle k+1: `busy`=1, `bit_start`=1, and `ser_out` = frame bit `FRAME_W`-1.
- Bit n (n = 0 is the first bit) occupies cycles k+1+n·`BIT_CYC` through k+(n+1)·`BIT_CYC`.
- `bit_start` is high in the first cycle of each bit.
- `busy` is high for exactly `FRAME_W`·`BIT_CYC` cycles.
- `done`=1 and `busy`=0 in cycle k+1+`FRAME_W`·`BIT_CYC`. `ser_out` returns to 0 in that cycle.
- Minimum spacing between frame starts: `FRAME_W`·`BIT_CYC`+1 cycles.

## Configuration
- Macro: `FRAME_PARITY_EN`.
- Defined:
  - An even-parity bit (XOR of all `msg` bits) is appended after the message LSB.
  - `FRAME_W` = `PRE_W`+`MSG_W`+1.
- Undefined:
  - No parity bit and no parity logic.
  - `FRAME_W` = `PRE_W`+`MSG_W`.

## Test plan
- Basic frame: defaults with `BIT_CYC`=4, parity off, `send`=1 at edge 0, `msg`=5'b10110.
  - `ser_out` = 0,1,0,1,1,0,1,1,0, each bit held for 4 cycles over cycles 1–36.
  - `bit_start` pulses at cycles 1, 5, …, 33.
  - `done`=1 and `busy`=0 at cycle 37.
- Parity on, same stimulus: a 10th bit = 1 (msg has three 1s), held over cycles 37–40; `done` at cycle 41.
  - With `msg`=5'b10100: parity bit = 0.
- Busy and back-to-back:
  - `send` pulses at cycles 10 and 20 while busy are ignored.
  - The frame is unchanged and `msg` changes mid-frame have no effect.
  - A `send` in the `done` cycle 37 starts a new frame with `busy`=1 at cycle 38.
- Reset mid-frame: `rst` asserted at cycle 15 drives all outputs to 0 immediately with no `done`. A `send` after release produces a full, correct frame.
- `BIT_CYC`=1, `MSG_W`=8, `PRE_W`=4:
  - 12 consecutive bits in cycles 1–12 with `bit_start` high on all of them.
  - `done` at cycle 13.
- Idle hold: with no `send` for 100 cycles after reset, `ser_out`, `busy`, `done` and `bit_start` stay 0.
